// File: rtl/priority_decoder_strobe.sv
// priority_decoder_strobe: holds one-hot out[in] for HOLD cycles then idles GAP cycles; `PRIORITY_DECODER_DROP_CNT_EN adds drop_cnt
module priority_decoder_strobe #(
  parameter int HOLD = 4,
  parameter int GAP = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] in,
  input  logic       v,
  output logic       ready,
  output logic [3:0] out,
  output logic       active,
  output logic       done,
  output logic [7:0] drop_cnt
);
  typedef enum logic [1:0] {S_IDLE, S_HOLD, S_GAP} state_t;
  state_t state;
  logic [7:0] cnt;
  always_comb ready = (state == S_IDLE);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt <= 8'd0;
      out <= 4'b0000;
      active <= 1'b0;
      done <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (v) begin
          out <= 4'b0001 << in;
          active <= 1'b1;
          done <= (HOLD == 1);
          cnt <= 8'(HOLD - 1);
          state <= S_HOLD;
        end
        S_HOLD: if (cnt != 8'd0) begin
          cnt <= cnt - 8'd1;
          done <= (cnt == 8'd1);
        end else begin
          out <= 4'b0000;
          active <= 1'b0;
          done <= 1'b0;
          cnt <= (GAP == 0) ? 8'd0 : 8'(GAP - 1);
          state <= (GAP == 0) ? S_IDLE : S_GAP;
        end
        S_GAP: begin
          cnt <= (cnt != 8'd0) ? cnt - 8'd1 : 8'd0;
          state <= (cnt != 8'd0) ? S_GAP : S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
`ifdef PRIORITY_DECODER_DROP_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) drop_cnt <= 8'd0;
    else if (v && !ready && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
  end
`else
  always_comb drop_cnt = 8'h00;
`endif
endmodule

// File: tb/tb_priority_decoder_strobe.sv
// tb_priority_decoder_strobe: scoreboard bench for priority_decoder_strobe
module tb_priority_decoder_strobe;
  localparam int H = 4;
  localparam int G = 1;
  localparam int H0 = 3;
`ifdef PRIORITY_DECODER_DROP_CNT_EN
  localparam bit DROP_EN = 1'b1;
`else
  localparam bit DROP_EN = 1'b0;
`endif
  typedef struct {
    logic [3:0] o;
    logic a;
    logic d;
    logic r;
    logic [7:0] dc;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [1:0] in = 2'b00;
  logic v = 1'b0;
  logic ready;
  logic [3:0] out;
  logic active;
  logic done;
  logic [7:0] drop_cnt;
  logic [1:0] in0 = 2'b00;
  logic v0 = 1'b0;
  logic ready0;
  logic [3:0] out0;
  logic active0;
  logic done0;
  logic [7:0] drop_cnt0;
  exp_t q[$];
  exp_t e;
  int n_cmp = 0;
  int n_err = 0;
  always #5 clk = ~clk;
  priority_decoder_strobe #(.HOLD(H), .GAP(G)) dut (
    .clk(clk), .rst_n(rst_n), .in(in), .v(v), .ready(ready),
    .out(out), .active(active), .done(done), .drop_cnt(drop_cnt)
  );
  priority_decoder_strobe #(.HOLD(H0), .GAP(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in(in0), .v(v0), .ready(ready0),
    .out(out0), .active(active0), .done(done0), .drop_cnt(drop_cnt0)
  );
  function automatic logic [7:0] dv(int x);
    return DROP_EN ? ((x > 255) ? 8'hFF : 8'(x)) : 8'h00;
  endfunction
  function automatic void push(logic [3:0] o, logic a, logic d, logic r, logic [7:0] dc);
    exp_t t;
    t.o = o;
    t.a = a;
    t.d = d;
    t.r = r;
    t.dc = dc;
    q.push_back(t);
  endfunction
  function automatic void push_strobe(int code, int ds, int inc);
    logic [3:0] oh;
    oh = 4'b0001 << code;
    for (int k = 1; k <= H; k++) push(oh, 1'b1, k == H, 1'b0, dv(ds + inc * (k - 1)));
    for (int g = 1; g <= G; g++) push(4'b0000, 1'b0, 1'b0, 1'b0, dv(ds + inc * (H + g - 1)));
  endfunction
  task automatic test_reset();
    rst_n = 1'b0;
    v = 1'b0;
    v0 = 1'b0;
    @(posedge clk);
    #1;
    n_cmp++;
    if ({out, active, done, ready, drop_cnt} !== {4'b0000, 1'b0, 1'b0, 1'b1, 8'h00}) begin
      n_err++;
      $display("FAIL reset: got out=%b act=%b done=%b rdy=%b drop=%h, expected 0000 0 0 1 00", out, active, done, ready, drop_cnt);
    end
    n_cmp++;
    if ({out0, active0, done0, ready0} !== {4'b0000, 1'b0, 1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL reset_gap0: got out=%b act=%b done=%b rdy=%b, expected 0000 0 0 1", out0, active0, done0, ready0);
    end
    rst_n = 1'b1;
  endtask
  task automatic test_single(input logic [1:0] code, input string tag);
    in = code;
    v = 1'b1;
    push_strobe(code, 0, 0);
    push(4'b0000, 1'b0, 1'b0, 1'b1, 8'h00);
    while (q.size() > 0) begin
      @(posedge clk);
      #1;
      v = 1'b0;
      e = q.pop_front();
      n_cmp++;
      if ({out, active, done, ready, drop_cnt} !== {e.o, e.a, e.d, e.r, e.dc}) begin
        n_err++;
        $display("FAIL %s: got out=%b act=%b done=%b rdy=%b drop=%h, expected %b %b %b %b %h",
                 tag, out, active, done, ready, drop_cnt, e.o, e.a, e.d, e.r, e.dc);
      end
    end
  endtask
  task automatic test_all_codes();
    for (int c = 0; c < 4; c++) test_single(2'(c), "all_codes");
  endtask
  task automatic test_drop();
    in = 2'b01;
    v = 1'b1;
    push_strobe(1, 0, 1);
    push(4'b0000, 1'b0, 1'b0, 1'b1, dv(H + G));
    push_strobe(1, H + G, 1);
    push(4'b0000, 1'b0, 1'b0, 1'b1, dv(2 * (H + G)));
    while (q.size() > 0) begin
      @(posedge clk);
      #1;
      e = q.pop_front();
      n_cmp++;
      if ({out, active, done, ready, drop_cnt} !== {e.o, e.a, e.d, e.r, e.dc}) begin
        n_err++;
        $display("FAIL drop: got out=%b act=%b done=%b rdy=%b drop=%h, expected %b %b %b %b %h",
                 out, active, done, ready, drop_cnt, e.o, e.a, e.d, e.r, e.dc);
      end
    end
    v = 1'b1;
    repeat (300) @(posedge clk);
    #1;
    v = 1'b0;
    n_cmp++;
    if (drop_cnt !== dv(300)) begin
      n_err++;
      $display("FAIL drop_sat: got drop=%h, expected %h", drop_cnt, dv(300));
    end
    repeat (H + G + 1) @(posedge clk);
    #1;
  endtask
  task automatic test_reset_mid();
    in = 2'b00;
    v = 1'b1;
    push(4'b0001, 1'b1, 1'b0, 1'b0, 8'h00);
    push(4'b0001, 1'b1, 1'b0, 1'b0, 8'h00);
    while (q.size() > 0) begin
      @(posedge clk);
      #1;
      v = 1'b0;
      e = q.pop_front();
      n_cmp++;
      if ({out, active, done, ready, drop_cnt} !== {e.o, e.a, e.d, e.r, e.dc}) begin
        n_err++;
        $display("FAIL reset_mid: got out=%b act=%b done=%b rdy=%b drop=%h, expected %b %b %b %b %h",
                 out, active, done, ready, drop_cnt, e.o, e.a, e.d, e.r, e.dc);
      end
    end
    rst_n = 1'b0;
    push(4'b0000, 1'b0, 1'b0, 1'b1, 8'h00);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      if (k == 0) e = q.pop_front();
      n_cmp++;
      if ({out, active, done, ready} !== {4'b0000, 1'b0, 1'b0, 1'b1}) begin
        n_err++;
        $display("FAIL reset_mid_abort: got out=%b act=%b done=%b rdy=%b, expected 0000 0 0 1", out, active, done, ready);
      end
    end
    test_single(2'b10, "after_reset");
  endtask
  task automatic test_back_to_back();
    in0 = 2'b11;
    v0 = 1'b1;
    for (int r = 0; r < 3; r++) begin
      for (int k = 1; k <= H0; k++) push(4'b1000, 1'b1, k == H0, 1'b0, 8'h00);
      push(4'b0000, 1'b0, 1'b0, 1'b1, 8'h00);
    end
    while (q.size() > 0) begin
      @(posedge clk);
      #1;
      e = q.pop_front();
      n_cmp++;
      if ({out0, active0, done0, ready0} !== {e.o, e.a, e.d, e.r}) begin
        n_err++;
        $display("FAIL back_to_back: got out=%b act=%b done=%b rdy=%b, expected %b %b %b %b",
                 out0, active0, done0, ready0, e.o, e.a, e.d, e.r);
      end
    end
    v0 = 1'b0;
    repeat (H0 + 1) @(posedge clk);
    #1;
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_single(2'b10, "single");
    test_all_codes();
    test_back_to_back();
    test_reset();
    test_drop();
    test_reset();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
